// File: rtl/prog_loader_pkg.sv
// Shared types and frame constants for the program loader.
// Frame layout: sync, 16-bit little-endian word count, payload words, XOR checksum.
package prog_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEN0,
        ST_LEN1,
        ST_DATA,
        ST_CHK,
        ST_DONE,
        ST_ERR
    } state_e;

    localparam logic [7:0] SYNC_BYTE      = 8'hA5;
    localparam int         LEN_W          = 16;
    localparam int         WORD_W         = 32;
    localparam int         BYTES_PER_WORD = 4;
    localparam int         BCNT_W         = 2;

endpackage

// File: rtl/loader_word_asm.sv
// Byte-to-word assembler: collects payload bytes LSB first and keeps the running XOR.
// word_last/word_next are combinational so the owner can register the write on the 4th byte edge.
module loader_word_asm
    import prog_loader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              byte_en,
    input  logic [7:0]        byte_in,
    output logic              word_last,
    output logic [WORD_W-1:0] word_next,
    output logic [7:0]        xor_acc
);

    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [WORD_W-1:0] word_q, word_d;
    logic [7:0]        xor_q, xor_d;

    // Shifting in from the top leaves the first byte in [7:0] after four bytes.
    always_comb begin
        word_next = {byte_in, word_q[WORD_W-1:8]};
        word_last = byte_en && (cnt_q == BCNT_W'(BYTES_PER_WORD - 1));
        cnt_d     = cnt_q;
        word_d    = word_q;
        xor_d     = xor_q;
        if (byte_en) begin
            cnt_d  = cnt_q + 1'b1;
            word_d = word_next;
            xor_d  = xor_q ^ byte_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            word_q <= '0;
            xor_q  <= '0;
        end else begin
            cnt_q  <= cnt_d;
            word_q <= word_d;
            xor_q  <= xor_d;
        end
    end

    assign xor_acc = xor_q;

endmodule

// File: rtl/prog_loader.sv
// Streams a framed program image from a byte channel into instruction memory,
// then releases the CPU via start, or latches err on a bad length or checksum.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx_valid,
    input  logic [7:0]        rx_data,
    output logic              rx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic              start,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic [7:0]        len_lo_q, len_lo_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic [LEN_W-1:0]  wcnt_q, wcnt_d;
    logic              imem_we_q, imem_we_d;
    logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
    logic [31:0]       imem_wdata_q, imem_wdata_d;

    logic              accept;
    logic              payload_en;
    logic              word_last;
    logic [WORD_W-1:0] word_next;
    logic [7:0]        xor_acc;
    logic [LEN_W-1:0]  len_full;

    assign accept     = rx_valid && rx_ready;
    assign payload_en = accept && (state_q == ST_DATA);
    assign len_full   = {rx_data, len_lo_q};

    loader_word_asm u_asm (
        .clk       (clk),
        .rst_n     (rst_n),
        .byte_en   (payload_en),
        .byte_in   (rx_data),
        .word_last (word_last),
        .word_next (word_next),
        .xor_acc   (xor_acc)
    );

    // Handshake and status are decoded from state alone, never from rx_valid.
    always_comb begin
        rx_ready = (state_q != ST_DONE) && (state_q != ST_ERR);
        busy     = (state_q == ST_LEN0) || (state_q == ST_LEN1) ||
                   (state_q == ST_DATA) || (state_q == ST_CHK);
        start    = (state_q == ST_DONE);
        err      = (state_q == ST_ERR);
    end

    always_comb begin
        state_d      = state_q;
        len_lo_d     = len_lo_q;
        len_d        = len_q;
        wcnt_d       = wcnt_q;
        imem_we_d    = 1'b0;
        imem_addr_d  = imem_addr_q;
        imem_wdata_d = imem_wdata_q;
        case (state_q)
            ST_IDLE: if (accept && rx_data == SYNC_BYTE) state_d = ST_LEN0;
            ST_LEN0: if (accept) begin
                len_lo_d = rx_data;
                state_d  = ST_LEN1;
            end
            ST_LEN1: if (accept) begin
                len_d  = len_full;
                wcnt_d = '0;
                if (len_full > LEN_W'(DEPTH_WORDS)) state_d = ST_ERR;
                else if (len_full == '0)            state_d = ST_CHK;
                else                                state_d = ST_DATA;
            end
            ST_DATA: if (word_last) begin
                imem_we_d    = 1'b1;
                imem_addr_d  = wcnt_q[ADDR_W-1:0];
                imem_wdata_d = word_next;
                wcnt_d       = wcnt_q + 1'b1;
                if (wcnt_q + 1'b1 == len_q) state_d = ST_CHK;
            end
            ST_CHK: if (accept) state_d = (rx_data == xor_acc) ? ST_DONE : ST_ERR;
            default: state_d = state_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            len_lo_q     <= '0;
            len_q        <= '0;
            wcnt_q       <= '0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
        end else begin
            state_q      <= state_d;
            len_lo_q     <= len_lo_d;
            len_q        <= len_d;
            wcnt_q       <= wcnt_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
        end
    end

    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;

endmodule

// File: tb/tb_prog_loader.sv
// Randomised frame bench: a frame parser model predicts writes (with timing) and the
// final status; a negedge monitor pops expected writes whenever imem_we is seen.
module tb_prog_loader;

    localparam int DEPTH = 256;
    localparam int O_IDLE = 0, O_BUSY = 1, O_DONE = 2, O_ERR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_ready, imem_we, start, busy, err;
    logic [7:0]  imem_addr;
    logic [31:0] imem_wdata;

    prog_loader #(.DEPTH_WORDS(DEPTH), .ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .rx_valid(rx_valid), .rx_data(rx_data),
        .rx_ready(rx_ready), .imem_we(imem_we), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .start(start), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int cyc; logic [7:0] addr; logic [31:0] data; } wr_t;
    wr_t sb[$];

    int total = 0;
    int bad = 0;

    byte unsigned frame_q[$];
    int           m_nacc, m_outcome;
    int           m_trig[$];
    logic [31:0]  m_data[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr %h data %h want no write", imem_addr, imem_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_cycle", cyc, e.cyc);
                chk("wr_addr", 32'(imem_addr), 32'(e.addr));
                chk("wr_data", imem_wdata, e.data);
            end
        end
    end

    // Parses frame_q as a byte stream: which bytes get accepted, which byte completes
    // each word, and how the frame ends.
    task automatic model();
        int i, n, p, c;
        byte unsigned x;
        m_trig.delete();
        m_data.delete();
        i = 0;
        while (i < frame_q.size() && frame_q[i] != 8'hA5) i++;
        if (i >= frame_q.size()) begin
            m_nacc = frame_q.size(); m_outcome = O_IDLE; return;
        end
        if (i + 2 >= frame_q.size()) begin
            m_nacc = frame_q.size(); m_outcome = O_BUSY; return;
        end
        n = int'(frame_q[i+1]) + 256 * int'(frame_q[i+2]);
        p = i + 3;
        if (n > DEPTH) begin
            m_nacc = p; m_outcome = O_ERR; return;
        end
        x = 0;
        for (int w = 0; w < n; w++) begin
            if (p + 4*w + 3 < frame_q.size()) begin
                m_trig.push_back(p + 4*w + 3);
                m_data.push_back({frame_q[p+4*w+3], frame_q[p+4*w+2], frame_q[p+4*w+1], frame_q[p+4*w]});
            end
            for (int k = 0; k < 4; k++)
                if (p + 4*w + k < frame_q.size()) x ^= frame_q[p + 4*w + k];
        end
        c = p + 4*n;
        if (c < frame_q.size()) begin
            m_nacc = c + 1;
            m_outcome = (frame_q[c] == x) ? O_DONE : O_ERR;
        end else begin
            m_nacc = frame_q.size(); m_outcome = O_BUSY;
        end
    endtask

    task automatic run_frame(input int gap_pct);
        int idx = 0, wk = 0, guard = 0;
        model();
        while (idx < m_nacc && guard < 20000) begin
            @(negedge clk);
            guard++;
            rx_valid = ($urandom_range(99) >= gap_pct);
            rx_data  = frame_q[idx];
            if (rx_valid && rx_ready) begin
                if (wk < m_trig.size() && m_trig[wk] == idx) begin
                    sb.push_back('{cyc + 1, 8'(wk), m_data[wk]});
                    wk++;
                end
                idx++;
            end
        end
        chk("frame_timeout", 32'(idx), 32'(m_nacc));
        @(negedge clk);
        rx_valid = 1'b0;
        case (m_outcome)
            O_DONE: begin
                chk("done_start", start, 1); chk("done_err", err, 0);
                chk("done_busy", busy, 0);   chk("done_ready", rx_ready, 0);
            end
            O_ERR: begin
                chk("err_err", err, 1);    chk("err_start", start, 0);
                chk("err_busy", busy, 0);  chk("err_ready", rx_ready, 0);
            end
            O_BUSY: begin
                chk("mid_busy", busy, 1); chk("mid_start", start, 0); chk("mid_err", err, 0);
            end
            default: begin
                chk("idle_busy", busy, 0); chk("idle_ready", rx_ready, 1);
            end
        endcase
        if (m_nacc < frame_q.size() && (m_outcome == O_DONE || m_outcome == O_ERR)) begin
            repeat (3) begin
                rx_valid = 1'b1;
                rx_data  = frame_q[m_nacc];
                chk("closed_ready", rx_ready, 0);
                @(negedge clk);
            end
            rx_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);   chk("rst_ready", rx_ready, 1);
        chk("rst_start", start, 0); chk("rst_err", err, 0);
        chk("rst_we", imem_we, 0);
        repeat (2) @(negedge clk);
        chk("rst_addr", 32'(imem_addr), 0);
        chk("rst_wdata", imem_wdata, 0);
        rst_n = 1'b1;
    endtask

    task automatic build_frame(input int n, input bit good, input int lead);
        byte unsigned x, b;
        frame_q.delete();
        for (int i = 0; i < lead; i++) begin
            b = 8'($urandom_range(255));
            frame_q.push_back(b == 8'hA5 ? 8'h00 : b);
        end
        frame_q.push_back(8'hA5);
        frame_q.push_back(8'(n));
        frame_q.push_back(8'(n >> 8));
        x = 0;
        for (int i = 0; i < 4*n; i++) begin
            b = 8'($urandom_range(255));
            x ^= b;
            frame_q.push_back(b);
        end
        frame_q.push_back(good ? x : (x ^ 8'($urandom_range(1, 255))));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Two known words; the trailing byte is the true XOR of the payload (0xB0).
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                    8'h93, 8'h05, 8'h20, 8'h00, 8'hB0};
        run_frame(0);
        do_reset();
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h13, 8'h05, 8'h10, 8'h00,
                    8'h93, 8'h05, 8'h20, 8'h00, 8'h01};
        run_frame(0);
        do_reset();
        frame_q = '{8'h00, 8'hFF, 8'hA5, 8'h00, 8'h00, 8'h00};
        run_frame(0);
        do_reset();
        frame_q = '{8'hA5, 8'h01, 8'h01, 8'h11, 8'h22, 8'h33};
        run_frame(0);
        do_reset();

        // Same 3-word payload gapless and with random rx_valid gaps.
        build_frame(3, 1'b1, 0);
        run_frame(0);
        do_reset();
        run_frame(50);
        do_reset();

        // Largest legal image.
        build_frame(DEPTH, 1'b1, 1);
        run_frame(0);
        do_reset();

        for (int t = 0; t < 10; t++) begin
            build_frame($urandom_range(0, 6), ($urandom_range(0, 3) != 0), $urandom_range(0, 3));
            run_frame($urandom_range(0, 60));
            do_reset();
        end

        // Abandon a frame after six payload bytes, then load a fresh one-word image.
        frame_q = '{8'hA5, 8'h02, 8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_frame(0);
        do_reset();
        build_frame(1, 1'b1, 0);
        run_frame(30);

        repeat (5) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
